// File: rtl/grf_pkg.sv
// Shared widths and constants for the register-file writeback path.
package grf_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; on a tie the
// FIRST_PRIO requester wins unless it was the one granted last time.
module rr_arb2
    import grf_pkg::*;
#(
    parameter int FIRST_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);
    localparam logic PRIO = 1'(FIRST_PRIO);

    logic tie_winner;

    always_comb begin
        tie_winner = (last_grant == PRIO) ? ~PRIO : PRIO;
        grant      = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = tie_winner ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/grf_wb_arbiter.sv
// Arbitrates pipeline and mult/div writebacks into one GRF write port with
// a one-cycle output register and bypass hit detection. Define
// GRF_WB_TRACE_EN to print each committed write.
module grf_wb_arbiter
    import grf_pkg::*;
#(
    parameter int FIRST_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [REG_ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0]     req0_data,
    input  logic [DATA_W-1:0]     req0_pc,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [REG_ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0]     req1_data,
    input  logic [DATA_W-1:0]     req1_pc,
    output logic                  grf_we,
    output logic [REG_ADDR_W-1:0] grf_a3,
    output logic [DATA_W-1:0]     grf_wd,
    output logic [DATA_W-1:0]     grf_pc,
    input  logic [REG_ADDR_W-1:0] rd_a1,
    input  logic [REG_ADDR_W-1:0] rd_a2,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [DATA_W-1:0]     fwd_data
);
    localparam logic RESET_LAST = ~1'(FIRST_PRIO);

    logic                  last_grant_q, last_grant_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0]     wd_q, wd_d;
    logic [DATA_W-1:0]     pc_q, pc_d;
    logic [1:0]            req, grant;

    // Requests are masked during reset so nothing is granted or accepted.
    assign req = reset ? 2'b00 : {req1_valid, req0_valid};

    rr_arb2 #(.FIRST_PRIO(FIRST_PRIO)) u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        last_grant_d = last_grant_q;
        we_d         = 1'b0;
        a3_d         = a3_q;
        wd_d         = wd_q;
        pc_d         = pc_q;
        if (grant[1]) begin
            last_grant_d = 1'b1;
            we_d         = (req1_addr != ZERO_REG);
            a3_d         = req1_addr;
            wd_d         = req1_data;
            pc_d         = req1_pc;
        end else if (grant[0]) begin
            last_grant_d = 1'b0;
            we_d         = (req0_addr != ZERO_REG);
            a3_d         = req0_addr;
            wd_d         = req0_data;
            pc_d         = req0_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= RESET_LAST;
            we_q         <= 1'b0;
            a3_q         <= ZERO_REG;
            wd_q         <= '0;
            pc_q         <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            a3_q         <= a3_d;
            wd_q         <= wd_d;
            pc_q         <= pc_d;
        end
    end

    assign grf_we   = we_q;
    assign grf_a3   = a3_q;
    assign grf_wd   = wd_q;
    assign grf_pc   = pc_q;
    assign fwd1_hit = we_q && (a3_q == rd_a1) && (rd_a1 != ZERO_REG);
    assign fwd2_hit = we_q && (a3_q == rd_a2) && (rd_a2 != ZERO_REG);
    assign fwd_data = wd_q;

`ifdef GRF_WB_TRACE_EN
    always @(posedge clk) begin
        if (we_q)
            $display("@%08h: $%0d <= %08h", pc_q, a3_q, wd_q);
    end
`else
`endif
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed test of grf_wb_arbiter with hand-computed expectations.
module tb_grf_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data, req0_pc;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data, req1_pc;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc;
    logic [4:0]  rd_a1, rd_a2;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    grf_wb_arbiter #(.FIRST_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_pc(req0_pc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_pc(req1_pc),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .rd_a1(rd_a1), .rd_a2(rd_a2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [31:0] p0, input logic v1, input logic [4:0] a1,
                         input logic [31:0] d1, input logic [31:0] p1);
        req0_valid = v0; req0_addr = a0; req0_data = d0; req0_pc = p0;
        req1_valid = v1; req1_addr = a1; req1_data = d1; req1_pc = p1;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    // Expected grant sequence for a 4-cycle tie from reset with FIRST_PRIO=0.
    logic exp_grant [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        reset = 1'b1;
        rd_a1 = 5'd0;
        rd_a2 = 5'd0;
        drive(1, 5'd7, 32'h1, 32'h0, 1, 5'd9, 32'h2, 32'h0);
        check("rst_ready0", {31'b0, req0_ready}, 32'd0);
        check("rst_ready1", {31'b0, req1_ready}, 32'd0);
        step();
        step();
        check("rst_we", {31'b0, grf_we}, 32'd0);
        check("rst_a3", {27'b0, grf_a3}, 32'd0);
        check("rst_wd", grf_wd, 32'd0);
        check("rst_pc", grf_pc, 32'd0);
        reset = 1'b0;

        // Single requester write
        drive(1, 5'd5, 32'h1234_5678, 32'h3000, 0, 5'd0, 32'h0, 32'h0);
        check("single_ready0", {31'b0, req0_ready}, 32'd1);
        check("single_ready1", {31'b0, req1_ready}, 32'd0);
        step();
        check("single_we", {31'b0, grf_we}, 32'd1);
        check("single_a3", {27'b0, grf_a3}, 32'd5);
        check("single_wd", grf_wd, 32'h1234_5678);
        check("single_pc", grf_pc, 32'h3000);

        // Idle cycle: we drops, data holds
        drive(0, 5'd6, 32'h0, 32'h0, 0, 5'd6, 32'h0, 32'h0);
        step();
        check("idle_we", {31'b0, grf_we}, 32'd0);
        check("idle_a3_hold", {27'b0, grf_a3}, 32'd5);
        check("idle_wd_hold", grf_wd, 32'h1234_5678);

        // Tie for 4 cycles from reset alternates starting with requester 0
        do_reset();
        drive(1, 5'd10, 32'hA0, 32'h100, 1, 5'd20, 32'hB0, 32'h200);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("tie%0d_ready0", i), {31'b0, req0_ready}, {31'b0, ~exp_grant[i]});
            check($sformatf("tie%0d_ready1", i), {31'b0, req1_ready}, {31'b0, exp_grant[i]});
            step();
            check($sformatf("tie%0d_we", i), {31'b0, grf_we}, 32'd1);
            check($sformatf("tie%0d_a3", i), {27'b0, grf_a3}, exp_grant[i] ? 32'd20 : 32'd10);
        end

        // Write to $0 accepted but suppressed
        drive(0, 5'd0, 32'h0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF, 32'h400);
        check("zero_ready1", {31'b0, req1_ready}, 32'd1);
        step();
        check("zero_we", {31'b0, grf_we}, 32'd0);
        check("zero_wd", grf_wd, 32'hFFFF_FFFF);
        check("zero_fwd_a0", {31'b0, fwd1_hit}, 32'd0);

        // Forwarding from an in-flight write to $8
        drive(1, 5'd8, 32'hDEAD_BEEF, 32'h500, 0, 5'd0, 32'h0, 32'h0);
        step();
        drive(0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0);
        rd_a1 = 5'd8;
        rd_a2 = 5'd0;
        #1;
        check("fwd1_hit", {31'b0, fwd1_hit}, 32'd1);
        check("fwd2_hit_zero", {31'b0, fwd2_hit}, 32'd0);
        check("fwd_data", fwd_data, 32'hDEAD_BEEF);
        rd_a2 = 5'd8;
        rd_a1 = 5'd9;
        #1;
        check("fwd2_hit", {31'b0, fwd2_hit}, 32'd1);
        check("fwd1_miss", {31'b0, fwd1_hit}, 32'd0);
        step();
        check("fwd_stale", {31'b0, fwd2_hit}, 32'd0);
        rd_a1 = 5'd0;
        rd_a2 = 5'd0;

        // Valid dropped without a transfer leaves no trace
        reset = 1'b1;
        drive(1, 5'd12, 32'h77, 32'h0, 0, 5'd0, 32'h0, 32'h0);
        step();
        reset = 1'b0;
        drive(0, 5'd12, 32'h77, 32'h0, 0, 5'd0, 32'h0, 32'h0);
        step();
        check("drop_we", {31'b0, grf_we}, 32'd0);

        // Reset right after a transfer to $3 kills the write and restores priority
        drive(1, 5'd3, 32'h33, 32'h600, 0, 5'd0, 32'h0, 32'h0);
        step();
        check("pre_rst_we", {31'b0, grf_we}, 32'd1);
        reset = 1'b1;
        drive(1, 5'd4, 32'h44, 32'h0, 1, 5'd4, 32'h44, 32'h0);
        check("rst2_ready0", {31'b0, req0_ready}, 32'd0);
        check("rst2_ready1", {31'b0, req1_ready}, 32'd0);
        step();
        check("rst2_we", {31'b0, grf_we}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_tie_ready0", {31'b0, req0_ready}, 32'd1);
        check("post_rst_tie_ready1", {31'b0, req1_ready}, 32'd0);
        step();
        check("post_rst_a3", {27'b0, grf_a3}, 32'd4);

        // Trace sample write
        drive(1, 5'd31, 32'h0000_00AB, 32'h3004, 0, 5'd0, 32'h0, 32'h0);
        step();
        drive(0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 32'h0);
        check("trace_a3", {27'b0, grf_a3}, 32'd31);
        check("trace_pc", grf_pc, 32'h3004);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
